kernel_cc_fifo_rr_arbiter: RTL and testbench

- Merges NUM_SRC FIFO read-side streams into one downstream FIFO write port. The read-side streams follow the empty_n/read/dout convention, with dout valid whenever empty_n=1. The downstream port follows the full_n/write/din convention.
- Round-robin grant with bounded bursts: a granted source keeps the port for up to MAX_BURST words. Bursts keep per-source locality without starving the other sources.
- Sits between the per-PE shift-register FIFOs of kernel_cc and the shared edge/vertex update FIFO.
- Each emitted word is tagged with its source index.

---
 rtl/kernel_cc_arb_pkg.sv | 25 ++
 rtl/kernel_cc_rr_pick.sv | 32 +++
 rtl/kernel_cc_fifo_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_kernel_cc_fifo_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_cc_arb_pkg.sv
// Shared types and constants for the kernel_cc FIFO round-robin arbiter.
package kernel_cc_arb_pkg;

    // Arbiter FSM encoding: IDLE picks a source, GRANT streams its words.
    typedef enum logic {
        Idle  = 1'b0,
        Grant = 1'b1
    } arb_state_e;

    // Width of the per-grant burst counter; bounds MAX_BURST to 255.
    localparam int unsigned BurstCntWidth = 8;

    // Ceiling log2, used to cross-check SRC_WIDTH against NUM_SRC.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/kernel_cc_rr_pick.sv
// Circular priority search: first asserted request at or after ptr, wrapping
// modulo NUM_SRC so indices >= NUM_SRC are never produced.
module kernel_cc_rr_pick #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned SRC_WIDTH = 2
) (
    input  logic [NUM_SRC-1:0]   req,
    input  logic [SRC_WIDTH-1:0] ptr,
    output logic [SRC_WIDTH-1:0] idx,
    output logic                 any
);

    int unsigned          cand;
    logic [SRC_WIDTH-1:0] cand_idx;

    // Walk the sources starting at ptr and keep the first requester found.
    always_comb begin
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand     = (32'(ptr) + i) % NUM_SRC;
            cand_idx = SRC_WIDTH'(cand);
            if (!any && req[cand_idx]) begin
                any = 1'b1;
                idx = cand_idx;
            end
        end
    end

endmodule

// File: rtl/kernel_cc_fifo_rr_arbiter.sv
// Merges NUM_SRC FIFO read streams into one downstream FIFO write port using
// round-robin grants with bursts of up to MAX_BURST words per grant.
module kernel_cc_fifo_rr_arbiter
    import kernel_cc_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRC_WIDTH  = 2,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_SRC-1:0]            in_empty_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_SRC-1:0]            in_read,
    input  logic                          out_full_n,
    output logic                          out_write,
    output logic [DATA_WIDTH-1:0]         out_din,
    output logic [SRC_WIDTH-1:0]          out_src,
    output logic                          busy
);

    // Elaboration-time parameter sanity checks.
    if (SRC_WIDTH != clog2(NUM_SRC)) begin : g_bad_src_width
        $error("SRC_WIDTH must equal clog2(NUM_SRC)");
    end
    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("NUM_SRC must be in 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..255");
    end

    localparam logic [BurstCntWidth-1:0] BurstLast = BurstCntWidth'(MAX_BURST - 1);
    localparam logic [SRC_WIDTH-1:0]     LastSrc   = SRC_WIDTH'(NUM_SRC - 1);

    arb_state_e                 state_q, state_d;
    logic [SRC_WIDTH-1:0]       grant_idx_q, grant_idx_d;
    logic [SRC_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BurstCntWidth-1:0]   burst_cnt_q, burst_cnt_d;

    logic [SRC_WIDTH-1:0]       pick_idx;
    logic                       pick_any;
    logic [DATA_WIDTH-1:0]      words [NUM_SRC];
    logic                       head_valid;
    logic                       fire;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_words
        assign words[k] = in_dout[k*DATA_WIDTH +: DATA_WIDTH];
    end

    kernel_cc_rr_pick #(
        .NUM_SRC   (NUM_SRC),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .req (in_empty_n),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Transfer qualifier; gated by reset so no pop/push leaks out mid-reset.
    always_comb begin
        head_valid = in_empty_n[grant_idx_q];
        fire       = (state_q == Grant) && head_valid && out_full_n && reset;
    end

    // Datapath outputs: always steered by the current grant index.
    always_comb begin
        in_read              = '0;
        in_read[grant_idx_q] = fire;
        out_write            = fire;
        out_din              = words[grant_idx_q];
        out_src              = grant_idx_q;
        busy                 = (state_q == Grant);
    end

    // Next-state: arbitrate in Idle, count burst words and release in Grant.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            Idle: begin
                if (enable && pick_any) begin
                    state_d     = Grant;
                    grant_idx_d = pick_idx;
                    // Pointer moves past the winner so it goes last next round.
                    rr_ptr_d    = (pick_idx == LastSrc) ? '0 : pick_idx + SRC_WIDTH'(1);
                    burst_cnt_d = '0;
                end
            end
            Grant: begin
                if (!head_valid) begin
                    state_d = Idle;
                end else if (fire) begin
                    burst_cnt_d = burst_cnt_q + BurstCntWidth'(1);
                    if (burst_cnt_q == BurstLast) begin
                        state_d = Idle;
                    end
                end
                // Otherwise stalled on out_full_n: hold grant and count.
            end
            default: state_d = Idle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= Idle;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_kernel_cc_fifo_rr_arbiter.sv
// Self-checking bench for kernel_cc_fifo_rr_arbiter: a per-cycle vector table
// for reset and a single-source stream, plus directed multi-cycle sequences.
module tb_kernel_cc_fifo_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, enable, out_full_n;
    logic [3:0]   in_empty_n;
    logic [127:0] in_dout;

    logic [3:0]  rd_a, rd_b;
    logic        wr_a, wr_b, busy_a, busy_b;
    logic [31:0] din_a, din_b;
    logic [1:0]  src_a, src_b;

    // Default configuration (MAX_BURST=8).
    kernel_cc_fifo_rr_arbiter #(
        .NUM_SRC(4), .DATA_WIDTH(32), .SRC_WIDTH(2), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_empty_n(in_empty_n),
        .in_dout(in_dout), .in_read(rd_a), .out_full_n(out_full_n),
        .out_write(wr_a), .out_din(din_a), .out_src(src_a), .busy(busy_a)
    );

    // Short-burst configuration (MAX_BURST=2) for the interleave test.
    kernel_cc_fifo_rr_arbiter #(
        .NUM_SRC(4), .DATA_WIDTH(32), .SRC_WIDTH(2), .MAX_BURST(2)
    ) dut_b2 (
        .clk(clk), .reset(reset), .enable(enable), .in_empty_n(in_empty_n),
        .in_dout(in_dout), .in_read(rd_b), .out_full_n(out_full_n),
        .out_write(wr_b), .out_din(din_b), .out_src(src_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit sel       = 1'b0;
    bit use_model = 1'b0;

    // Source FIFO models.
    logic [31:0] mem [4][32];
    int          head [4];
    int          tail [4];

    logic [3:0]  s_rd;
    logic        s_wr, s_busy;
    logic [31:0] s_din;
    logic [1:0]  s_src;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  emp;
        logic        full;
        logic [31:0] d2;
        logic [3:0]  rd;
        logic        wr;
        logic [1:0]  src;
        logic        busy;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        mem[k][tail[k]] = v;
        tail[k]++;
    endtask

    task automatic clear_q();
        for (int k = 0; k < 4; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < 4; k++) begin
            in_empty_n[k] = (head[k] != tail[k]);
            in_dout[k*32 +: 32] = (head[k] != tail[k]) ? mem[k][head[k]]
                                                        : (32'hDEAD_0000 | 32'(k));
        end
    endtask

    // One clock: drive, sample at negedge, then pop the model after posedge.
    task automatic cyc();
        if (use_model) refresh();
        @(negedge clk);
        s_rd   = sel ? rd_b   : rd_a;
        s_wr   = sel ? wr_b   : wr_a;
        s_din  = sel ? din_b  : din_a;
        s_src  = sel ? src_b  : src_a;
        s_busy = sel ? busy_b : busy_a;
        @(posedge clk);
        #1;
        if (use_model) begin
            for (int k = 0; k < 4; k++) begin
                if (s_rd[k]) head[k]++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    int          nw;
    int          bad_onehot;
    logic [1:0]  wsrc [16];
    logic [31:0] wdin [16];
    int          wcyc [16];
    logic [1:0]  esrc;
    logic [31:0] exp_din;

    initial begin
        //           rst   en    emp      full  d2     | rd       wr    src   busy
        tbl[0]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'b1111, 1'b1, 32'h0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 32'hA, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 32'hA, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 32'hB, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'b0100, 1'b1, 32'hC, 4'b0100, 1'b1, 2'd2, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 4'b0000, 1'b1, 32'hC, 4'b0000, 1'b0, 2'd2, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 4'b0000, 1'b1, 32'hC, 4'b0000, 1'b0, 2'd2, 1'b0};

        reset      = 1'b0;
        enable     = 1'b1;
        out_full_n = 1'b1;
        in_empty_n = 4'b1111;
        in_dout    = '0;
        clear_q();
        @(posedge clk);
        #1;
        cyc();  // establishes reset state before the first checked vector

        // Reset behaviour, first grant, and a 3-word stream from source 2.
        for (int i = 0; i < 13; i++) begin
            reset      = tbl[i].rst;
            enable     = tbl[i].en;
            in_empty_n = tbl[i].emp;
            out_full_n = tbl[i].full;
            in_dout    = {32'hC0DE_0003, tbl[i].d2, 32'hC0DE_0001, 32'hC0DE_0000};
            cyc();
            exp_din = (tbl[i].src == 2'd2) ? tbl[i].d2 : (32'hC0DE_0000 | 32'(tbl[i].src));
            chk($sformatf("vec%0d_read", i), 32'(s_rd), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_write", i), 32'(s_wr), 32'(tbl[i].wr));
            chk($sformatf("vec%0d_src", i), 32'(s_src), 32'(tbl[i].src));
            chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_din", i), s_din, exp_din);
        end

        // MAX_BURST=2 interleave across four sources, 4 words each.
        sel = 1'b1;
        use_model = 1'b1;
        clear_q();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) push(k, 32'h300 + 32'(k * 16 + i));
        end
        do_reset();
        nw = 0;
        bad_onehot = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (!$onehot0(s_rd)) bad_onehot++;
            if (s_wr) begin
                if (nw < 16) begin
                    wsrc[nw] = s_src;
                    wdin[nw] = s_din;
                    wcyc[nw] = c;
                end
                nw++;
            end
        end
        chk("t3_word_count", 32'(nw), 32'd16);
        chk("t3_onehot_read", 32'(bad_onehot), 32'd0);
        for (int n = 0; n < 16; n++) begin
            esrc = 2'((n / 2) % 4);
            chk($sformatf("t3_src%0d", n), 32'(wsrc[n]), 32'(esrc));
            chk($sformatf("t3_din%0d", n), wdin[n],
                32'h300 + 32'(esrc) * 16 + 32'((n / 8) * 2 + (n % 2)));
            chk($sformatf("t3_cycle%0d", n), 32'(wcyc[n]), 32'(1 + 3 * (n / 2) + (n % 2)));
        end

        // Stall mid-burst on source 1; burst length must stay MAX_BURST.
        sel = 1'b0;
        clear_q();
        for (int i = 0; i < 12; i++) push(1, 32'h400 + 32'(i));
        out_full_n = 1'b1;
        enable = 1'b1;
        do_reset();
        cyc();
        chk("t4_idle_write", 32'(s_wr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_pre_write", 32'(s_wr), 32'd1);
            chk("t4_pre_din", s_din, 32'h400 + 32'(i));
        end
        out_full_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_stall_read", 32'(s_rd), 32'd0);
            chk("t4_stall_write", 32'(s_wr), 32'd0);
            chk("t4_stall_busy", 32'(s_busy), 32'd1);
            chk("t4_stall_src", 32'(s_src), 32'd1);
        end
        out_full_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_post_write", 32'(s_wr), 32'd1);
            chk("t4_post_din", s_din, 32'h403 + 32'(i));
        end
        cyc();
        chk("t4_bubble_write", 32'(s_wr), 32'd0);
        chk("t4_bubble_busy", 32'(s_busy), 32'd0);
        cyc();
        chk("t4_regrant_din", s_din, 32'h408);
        chk("t4_regrant_write", 32'(s_wr), 32'd1);

        // enable=0 during a source-3 burst: burst finishes, then hold in Idle.
        clear_q();
        for (int i = 0; i < 20; i++) push(3, 32'h500 + 32'(i));
        do_reset();
        cyc();
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("t5_pre_din", s_din, 32'h500 + 32'(i));
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(0, 32'h600 + 32'(i));
        for (int i = 0; i < 2; i++) push(1, 32'h700 + 32'(i));
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t5_finish_write", 32'(s_wr), 32'd1);
            chk("t5_finish_src", 32'(s_src), 32'd3);
            chk("t5_finish_din", s_din, 32'h502 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_hold_write", 32'(s_wr), 32'd0);
            chk("t5_hold_busy", 32'(s_busy), 32'd0);
        end
        enable = 1'b1;
        cyc();
        chk("t5_resume_idle_write", 32'(s_wr), 32'd0);
        cyc();
        chk("t5_resume_write", 32'(s_wr), 32'd1);
        chk("t5_resume_src", 32'(s_src), 32'd0);
        chk("t5_resume_din", s_din, 32'h600);

        // Reset during a stall on source 2.
        clear_q();
        for (int i = 0; i < 5; i++) push(2, 32'h800 + 32'(i));
        out_full_n = 1'b1;
        do_reset();
        cyc();
        cyc();
        chk("t6_first_din", s_din, 32'h800);
        out_full_n = 1'b0;
        cyc();
        chk("t6_stall_busy", 32'(s_busy), 32'd1);
        for (int i = 0; i < 2; i++) push(0, 32'h900 + 32'(i));
        cyc();
        reset = 1'b0;
        out_full_n = 1'b1;
        cyc();
        chk("t6_reset_read", 32'(s_rd), 32'd0);
        chk("t6_reset_write", 32'(s_wr), 32'd0);
        reset = 1'b1;
        cyc();
        chk("t6_after_busy", 32'(s_busy), 32'd0);
        chk("t6_after_src", 32'(s_src), 32'd0);
        chk("t6_after_write", 32'(s_wr), 32'd0);
        cyc();
        chk("t6_regrant_read", 32'(s_rd), 32'b0001);
        chk("t6_regrant_src", 32'(s_src), 32'd0);
        chk("t6_regrant_din", s_din, 32'h900);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
